// File: rtl/ysyx_22040895_trap_ctrl.v
// Trap controller: sequences ecall entry and mret return through the M-mode CSRs
// and issues a one-cycle fetch redirect at the end of each sequence.
module ysyx_22040895_trap_ctrl #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned MCAUSE_ECALL = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ecall_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            busy_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            set_mepc_o,
   output logic [XLEN-1:0] wdata_mepc_o,
   output logic            set_mcause_o,
   output logic [XLEN-1:0] wdata_mcause_o,
   output logic            get_mepc_o,
   input  logic [XLEN-1:0] rdata_mepc_i,
   output logic            get_mtvec_o,
   input  logic [XLEN-1:0] rdata_mtvec_i,
   output logic            get_mstatus_o,
   output logic            set_mstatus_o,
   output logic [XLEN-1:0] wdata_mstatus_o,
   input  logic [XLEN-1:0] rdata_mstatus_i
);

   localparam int unsigned MIE_BIT  = 3;
   localparam int unsigned MPIE_BIT = 7;
   localparam int unsigned MPP_LSB  = 11;
   localparam int unsigned MPP_MSB  = 12;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      TRAP_SAVE   = 3'd1,
      TRAP_JUMP   = 3'd2,
      RET_RESTORE = 3'd3,
      RET_JUMP    = 3'd4
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] pc_q;

   // mtvec is direct-mode only, so its mode bits never reach the redirect target
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^rdata_mtvec_i[1:0];

   // State register and PC capture; requests are only sampled while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pc_q  <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && ecall_i) begin
            pc_q <= pc_i;
         end
      end
   end

   // Next-state and state-decoded strobes; mstatus is rewritten from its live read value
   always_comb begin
      state_next       = IDLE;
      busy_o           = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      set_mepc_o       = 1'b0;
      wdata_mepc_o     = '0;
      set_mcause_o     = 1'b0;
      wdata_mcause_o   = '0;
      get_mepc_o       = 1'b0;
      get_mtvec_o      = 1'b0;
      get_mstatus_o    = 1'b0;
      set_mstatus_o    = 1'b0;
      wdata_mstatus_o  = '0;

      case (state)
         IDLE: begin
            if (ecall_i) begin
               state_next = TRAP_SAVE;
            end else if (mret_i) begin
               state_next = RET_RESTORE;
            end else begin
               state_next = IDLE;
            end
         end
         TRAP_SAVE: begin
            busy_o                            = 1'b1;
            set_mepc_o                        = 1'b1;
            wdata_mepc_o                      = pc_q;
            set_mcause_o                      = 1'b1;
            wdata_mcause_o                    = XLEN'(MCAUSE_ECALL);
            get_mstatus_o                     = 1'b1;
            set_mstatus_o                     = 1'b1;
            wdata_mstatus_o                   = rdata_mstatus_i;
            wdata_mstatus_o[MPIE_BIT]         = rdata_mstatus_i[MIE_BIT];
            wdata_mstatus_o[MIE_BIT]          = 1'b0;
            wdata_mstatus_o[MPP_MSB:MPP_LSB]  = 2'b11;
            state_next                        = TRAP_JUMP;
         end
         TRAP_JUMP: begin
            busy_o           = 1'b1;
            get_mtvec_o      = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = {rdata_mtvec_i[XLEN-1:2], 2'b00};
            state_next       = IDLE;
         end
         RET_RESTORE: begin
            busy_o                            = 1'b1;
            get_mstatus_o                     = 1'b1;
            set_mstatus_o                     = 1'b1;
            wdata_mstatus_o                   = rdata_mstatus_i;
            wdata_mstatus_o[MIE_BIT]          = rdata_mstatus_i[MPIE_BIT];
            wdata_mstatus_o[MPIE_BIT]         = 1'b1;
            wdata_mstatus_o[MPP_MSB:MPP_LSB]  = 2'b11;
            state_next                        = RET_JUMP;
         end
         RET_JUMP: begin
            busy_o           = 1'b1;
            get_mepc_o       = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = rdata_mepc_i;
            state_next       = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
// Scoreboarded bench for the trap controller: a CSR file and an abstract trap/return
// model in the bench predict each redirect; a negedge monitor checks every cycle.
module tb_ysyx_22040895_trap_ctrl;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            ecall;
   logic            mret;
   logic [XLEN-1:0] pc_in;
   logic            busy_o;
   logic            redirect_valid_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            set_mepc_o;
   logic [XLEN-1:0] wdata_mepc_o;
   logic            set_mcause_o;
   logic [XLEN-1:0] wdata_mcause_o;
   logic            get_mepc_o;
   logic            get_mtvec_o;
   logic            get_mstatus_o;
   logic            set_mstatus_o;
   logic [XLEN-1:0] wdata_mstatus_o;

   // Bench-side CSR file, written only from the stimulus process
   logic [XLEN-1:0] csr_mepc;
   logic [XLEN-1:0] csr_mcause;
   logic [XLEN-1:0] csr_mtvec;
   logic [XLEN-1:0] csr_mstatus;

   // Abstract architectural model
   logic [XLEN-1:0] m_mepc;
   logic [XLEN-1:0] m_mcause;
   logic [XLEN-1:0] m_mtvec;
   logic [XLEN-1:0] m_ms;

   typedef struct {
      logic            is_trap;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] mstatus;
      logic [XLEN-1:0] mepc;
      logic [XLEN-1:0] mcause;
   } exp_t;

   exp_t q[$];
   int   cnt;
   int   checks;
   int   failures;

   always #5 clk = ~clk;

   ysyx_22040895_trap_ctrl #(.XLEN(XLEN), .MCAUSE_ECALL(11)) dut (
      .clk              (clk),
      .rst              (rst),
      .ecall_i          (ecall),
      .mret_i           (mret),
      .pc_i             (pc_in),
      .busy_o           (busy_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .set_mepc_o       (set_mepc_o),
      .wdata_mepc_o     (wdata_mepc_o),
      .set_mcause_o     (set_mcause_o),
      .wdata_mcause_o   (wdata_mcause_o),
      .get_mepc_o       (get_mepc_o),
      .rdata_mepc_i     (csr_mepc),
      .get_mtvec_o      (get_mtvec_o),
      .rdata_mtvec_i    (csr_mtvec),
      .get_mstatus_o    (get_mstatus_o),
      .set_mstatus_o    (set_mstatus_o),
      .wdata_mstatus_o  (wdata_mstatus_o),
      .rdata_mstatus_i  (csr_mstatus)
   );

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
   function automatic logic [XLEN-1:0] trap_ms(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] mie;
      mie = (s >> 3) & 64'd1;
      return (s & ~64'h1888) | (mie << 7) | 64'h1800;
   endfunction

   // Return: MIE <- MPIE, MPIE <- 1, MPP <- M
   function automatic logic [XLEN-1:0] ret_ms(input logic [XLEN-1:0] s);
      logic [XLEN-1:0] mpie;
      mpie = (s >> 7) & 64'd1;
      return (s & ~64'h1888) | (mpie << 3) | 64'h1880;
   endfunction

   task automatic set_csrs(input logic [XLEN-1:0] ms, input logic [XLEN-1:0] epc,
                           input logic [XLEN-1:0] tvec);
      csr_mstatus = ms;  m_ms    = ms;
      csr_mepc    = epc; m_mepc  = epc;
      csr_mtvec   = tvec; m_mtvec = tvec;
   endtask

   // One clock of stimulus, called at a negedge; commits DUT CSR writes and steps the model
   task automatic step(input logic e, input logic m, input logic [XLEN-1:0] pc);
      logic            wm, wc, ws;
      logic [XLEN-1:0] dm, dc, ds;
      exp_t            x;
      ecall = e;
      mret  = m;
      pc_in = pc;
      wm = set_mepc_o;    dm = wdata_mepc_o;
      wc = set_mcause_o;  dc = wdata_mcause_o;
      ws = set_mstatus_o; ds = wdata_mstatus_o;
      @(posedge clk);
      if (wm) csr_mepc    = dm;
      if (wc) csr_mcause  = dc;
      if (ws) csr_mstatus = ds;
      if (cnt != 0) begin
         cnt--;
      end else if (e || m) begin
         cnt = 2;
         if (e) begin
            m_mepc   = pc;
            m_mcause = 64'd11;
            m_ms     = trap_ms(m_ms);
            x = '{1'b1, m_mtvec & ~64'h3, m_ms, m_mepc, m_mcause};
         end else begin
            m_ms = ret_ms(m_ms);
            x = '{1'b0, m_mepc, m_ms, m_mepc, m_mcause};
         end
         q.push_back(x);
      end
      @(negedge clk);
   endtask

   // Monitor: per-cycle protocol checks and scoreboard pops on each redirect
   always @(negedge clk) begin
      exp_t e;
      chk("busy", XLEN'(busy_o), XLEN'(cnt != 0));
      chk("redirect_valid", XLEN'(redirect_valid_o), XLEN'(cnt == 1));
      if (!redirect_valid_o) chk("redirect_pc_idle", redirect_pc_o, '0);
      if (cnt == 0)
         chk("idle_strobes", XLEN'({set_mepc_o, set_mcause_o, get_mepc_o, get_mtvec_o,
                                    get_mstatus_o, set_mstatus_o}), '0);
      if (cnt == 2 && q.size() > 0) begin
         e = q[0];
         chk("save_strobes", XLEN'({set_mepc_o, set_mcause_o, get_mstatus_o, set_mstatus_o,
                                    get_mtvec_o, get_mepc_o}),
             e.is_trap ? 64'b111100 : 64'b001100);
      end
      if (redirect_valid_o) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_redirect actual=%h required=none", redirect_pc_o);
         end else begin
            e = q.pop_front();
            chk("redirect_pc", redirect_pc_o, e.pc);
            chk("jump_strobes", XLEN'({set_mepc_o, set_mcause_o, get_mstatus_o, set_mstatus_o,
                                       get_mtvec_o, get_mepc_o}),
                e.is_trap ? 64'b000010 : 64'b000001);
            chk("mstatus", csr_mstatus, e.mstatus);
            chk("mepc", csr_mepc, e.mepc);
            chk("mcause", csr_mcause, e.mcause);
         end
      end
   end

   initial begin
      logic [XLEN-1:0] old_mepc;
      logic [XLEN-1:0] old_mcause;
      logic [XLEN-1:0] old_ms;
      checks = 0;
      failures = 0;
      cnt = 0;
      rst = 1'b1;
      ecall = 1'b0;
      mret = 1'b0;
      pc_in = '0;
      csr_mcause = '0;
      m_mcause = '0;
      set_csrs(64'h8, 64'h0, 64'h8000_0101);
      #1;
      chk("reset_outputs", XLEN'({busy_o, redirect_valid_o, set_mepc_o, set_mcause_o, get_mepc_o,
                                  get_mtvec_o, get_mstatus_o, set_mstatus_o}), '0);
      chk("reset_wdata", wdata_mepc_o | wdata_mcause_o | wdata_mstatus_o | redirect_pc_o, '0);
      repeat (2) @(negedge clk);

      // ecall straight out of reset, then mret back
      rst = 1'b0;
      step(1'b1, 1'b0, 64'h8000_0010);
      repeat (3) step(1'b0, 1'b0, '0);
      chk("ecall_mstatus", csr_mstatus, 64'h1880);
      set_csrs(csr_mstatus, 64'h8000_0014, csr_mtvec);
      step(1'b0, 1'b1, '0);
      repeat (3) step(1'b0, 1'b0, '0);
      chk("mret_mstatus", csr_mstatus, 64'h1888);

      // simultaneous ecall and mret: trap only
      step(1'b1, 1'b1, 64'h8000_0200);
      repeat (3) step(1'b0, 1'b0, '0);

      // mret during TRAP_SAVE ignored; held ecall gives back-to-back traps
      step(1'b1, 1'b0, 64'h8000_0300);
      step(1'b0, 1'b1, '0);
      repeat (2) step(1'b0, 1'b0, '0);
      repeat (6) step(1'b1, 1'b0, 64'h8000_0400);
      repeat (3) step(1'b0, 1'b0, '0);

      // reset during TRAP_SAVE aborts before any write commits
      old_mepc = csr_mepc;
      old_mcause = csr_mcause;
      old_ms = csr_mstatus;
      ecall = 1'b1;
      pc_in = 64'h8000_0500;
      @(posedge clk);
      #2;
      rst = 1'b1;
      cnt = 0;
      q.delete();
      #1;
      chk("abort_outputs", XLEN'({busy_o, redirect_valid_o, set_mepc_o, set_mcause_o, get_mepc_o,
                                  get_mtvec_o, get_mstatus_o, set_mstatus_o}), '0);
      ecall = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_mepc", csr_mepc, old_mepc);
      chk("abort_mcause", csr_mcause, old_mcause);
      chk("abort_mstatus", csr_mstatus, old_ms);
      rst = 1'b0;
      step(1'b1, 1'b0, 64'h8000_0600);
      repeat (3) step(1'b0, 1'b0, '0);

      // long idle stretch
      repeat (100) step(1'b0, 1'b0, {$urandom, $urandom});

      // randomized traffic with occasional CSR reloads while idle
      repeat (400) begin
         if (cnt == 0 && $urandom_range(0, 9) == 0)
            set_csrs({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, {$urandom, $urandom});
      end
      repeat (4) step(1'b0, 1'b0, '0);
      chk("scoreboard_empty", XLEN'(q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
